// File: rtl/click_pkg.sv
// Shared types and event codes for the click classifier.
package click_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT2 = 2'd1,
        WAIT3 = 2'd2
    } state_e;

    localparam logic [1:0] EVT_NONE   = 2'd0;
    localparam logic [1:0] EVT_SINGLE = 2'd1;
    localparam logic [1:0] EVT_DOUBLE = 2'd2;
    localparam logic [1:0] EVT_TRIPLE = 2'd3;

endpackage

// File: rtl/gap_timer.sv
// Inter-press gap timer: clear has priority over enable; tc flags the last in-window cycle.
module gap_timer #(
    parameter int unsigned WINDOW_CYCLES = 25_000_000,
    parameter int unsigned TMR_W         = $clog2(WINDOW_CYCLES)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The owning FSM clears on every transition, so the count never passes tc.
    assign tc_o = (cnt_q == TMR_W'(WINDOW_CYCLES - 1));

endmodule

// File: rtl/click_classifier.sv
// Classifies bursts of debounced press pulses into single/double/triple click events.
module click_classifier
    import click_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 25_000_000
) (
    input  logic       ckht,
    input  logic       rst,
    input  logic       xcdlh,
    output logic       single_click,
    output logic       double_click,
    output logic       triple_click,
    output logic [1:0] last_evt,
    output logic       busy
);

    localparam int unsigned TMR_W = $clog2(WINDOW_CYCLES);

    state_e     state_q, state_d;
    logic       single_q, single_d;
    logic       double_q, double_d;
    logic       triple_q, triple_d;
    logic [1:0] evt_q, evt_d;
    logic       tmr_clr, tmr_en, tmr_tc;

    gap_timer #(
        .WINDOW_CYCLES(WINDOW_CYCLES),
        .TMR_W        (TMR_W)
    ) u_gap_timer (
        .clk_i(ckht),
        .rst_i(rst),
        .clr_i(tmr_clr),
        .en_i (tmr_en),
        .tc_o (tmr_tc)
    );

    // A press always takes priority over a coincident timeout.
    always_comb begin
        state_d  = state_q;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        single_d = 1'b0;
        double_d = 1'b0;
        triple_d = 1'b0;
        evt_d    = evt_q;
        unique case (state_q)
            IDLE: begin
                if (xcdlh) begin
                    state_d = WAIT2;
                    tmr_clr = 1'b1;
                end
            end
            WAIT2: begin
                tmr_en = 1'b1;
                if (xcdlh) begin
                    state_d = WAIT3;
                    tmr_clr = 1'b1;
                end else if (tmr_tc) begin
                    state_d  = IDLE;
                    tmr_clr  = 1'b1;
                    single_d = 1'b1;
                    evt_d    = EVT_SINGLE;
                end
            end
            WAIT3: begin
                tmr_en = 1'b1;
                if (xcdlh) begin
                    state_d  = IDLE;
                    tmr_clr  = 1'b1;
                    triple_d = 1'b1;
                    evt_d    = EVT_TRIPLE;
                end else if (tmr_tc) begin
                    state_d  = IDLE;
                    tmr_clr  = 1'b1;
                    double_d = 1'b1;
                    evt_d    = EVT_DOUBLE;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge ckht) begin
        if (rst) begin
            state_q  <= IDLE;
            single_q <= 1'b0;
            double_q <= 1'b0;
            triple_q <= 1'b0;
            evt_q    <= EVT_NONE;
        end else begin
            state_q  <= state_d;
            single_q <= single_d;
            double_q <= double_d;
            triple_q <= triple_d;
            evt_q    <= evt_d;
        end
    end

    assign single_click = single_q;
    assign double_click = double_q;
    assign triple_click = triple_q;
    assign last_evt     = evt_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_click_classifier.sv
// Bench for click_classifier: directed scenarios plus random presses against a burst-level model.
module tb_click_classifier;

    localparam int unsigned W = 8;

    logic       ckht = 1'b0;
    logic       rst = 1'b1;
    logic       xcdlh = 1'b0;
    logic       single_click, double_click, triple_click, busy;
    logic [1:0] last_evt;

    click_classifier #(
        .WINDOW_CYCLES(W)
    ) dut (
        .ckht        (ckht),
        .rst         (rst),
        .xcdlh       (xcdlh),
        .single_click(single_click),
        .double_click(double_click),
        .triple_click(triple_click),
        .last_evt    (last_evt),
        .busy        (busy)
    );

    always #5 ckht = ~ckht;

    int n_tests = 0;
    int n_fail = 0;

    // Burst-level model: presses counted so far and time of the latest one.
    int         e;
    int         burst_n;
    int         last_t;
    logic       m_single, m_double, m_triple;
    logic [1:0] m_evt;

    task automatic tick(input logic p, input logic r);
        xcdlh = p;
        rst   = r;
        @(posedge ckht);
        e++;
        m_single = 1'b0;
        m_double = 1'b0;
        m_triple = 1'b0;
        if (r) begin
            burst_n = 0;
            m_evt   = 2'd0;
        end else if (p) begin
            if (burst_n == 2) begin
                burst_n  = 0;
                m_triple = 1'b1;
                m_evt    = 2'd3;
            end else begin
                burst_n++;
                last_t = e;
            end
        end else if (burst_n > 0 && (e - last_t) == int'(W)) begin
            if (burst_n == 1) begin
                m_single = 1'b1;
                m_evt    = 2'd1;
            end else begin
                m_double = 1'b1;
                m_evt    = 2'd2;
            end
            burst_n = 0;
        end
        #1;
    endtask

    function automatic logic [5:0] dut_vec();
        return {single_click, double_click, triple_click, last_evt, busy};
    endfunction

    function automatic logic [5:0] mdl_vec();
        return {m_single, m_double, m_triple, m_evt, logic'(burst_n != 0)};
    endfunction

    function automatic logic has(input int q[$], input int k);
        foreach (q[i]) if (q[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic restart();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        e = 0;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1);
        n_tests++;
        if (dut_vec() !== 6'b0) begin
            n_fail++;
            $display("FAIL reset: got %b want %b", dut_vec(), 6'b0);
        end
    endtask

    task automatic test_single();
        int q[$] = '{10};
        int hits = 0;
        restart();
        for (int k = 1; k <= 30; k++) begin
            tick(has(q, k), 1'b0);
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL single edge %0d: got %b want %b", k, dut_vec(), mdl_vec());
            end
            if (single_click) hits++;
            if (k == 18) begin
                n_tests++;
                if (single_click !== 1'b1 || last_evt !== 2'd1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_at_18: got s=%b evt=%0d busy=%b want 1/1/0",
                             single_click, last_evt, busy);
                end
            end
        end
        n_tests++;
        if (hits !== 1) begin
            n_fail++;
            $display("FAIL single_count: got %0d want 1", hits);
        end
    endtask

    task automatic test_double();
        int q[$] = '{10, 15};
        restart();
        for (int k = 1; k <= 35; k++) begin
            tick(has(q, k), 1'b0);
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL double edge %0d: got %b want %b", k, dut_vec(), mdl_vec());
            end
            if (k == 23) begin
                n_tests++;
                if (double_click !== 1'b1 || last_evt !== 2'd2) begin
                    n_fail++;
                    $display("FAIL double_at_23: got d=%b evt=%0d want 1/2",
                             double_click, last_evt);
                end
            end
        end
    endtask

    task automatic test_triple();
        int q[$] = '{10, 13, 16};
        restart();
        for (int k = 1; k <= 30; k++) begin
            tick(has(q, k), 1'b0);
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL triple edge %0d: got %b want %b", k, dut_vec(), mdl_vec());
            end
            if (k == 16) begin
                n_tests++;
                if (triple_click !== 1'b1 || last_evt !== 2'd3 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL triple_at_16: got t=%b evt=%0d busy=%b want 1/3/0",
                             triple_click, last_evt, busy);
                end
            end
        end
    endtask

    task automatic test_window_boundary();
        int qa[$] = '{10, 18};
        int qb[$] = '{10, 19};
        int singles = 0;
        restart();
        for (int k = 1; k <= 35; k++) begin
            tick(has(qa, k), 1'b0);
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL window_in edge %0d: got %b want %b", k, dut_vec(), mdl_vec());
            end
            if (k == 26) begin
                n_tests++;
                if (double_click !== 1'b1) begin
                    n_fail++;
                    $display("FAIL window_in_double_at_26: got %b want 1", double_click);
                end
            end
        end
        restart();
        for (int k = 1; k <= 40; k++) begin
            tick(has(qb, k), 1'b0);
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL window_out edge %0d: got %b want %b", k, dut_vec(), mdl_vec());
            end
            if (single_click) singles++;
            if (k == 27) begin
                n_tests++;
                if (single_click !== 1'b1) begin
                    n_fail++;
                    $display("FAIL window_out_single_at_27: got %b want 1", single_click);
                end
            end
        end
        n_tests++;
        if (singles !== 2) begin
            n_fail++;
            $display("FAIL window_out_single_count: got %0d want 2", singles);
        end
    endtask

    task automatic test_reset_mid_burst();
        int q[$] = '{10, 20};
        restart();
        for (int k = 1; k <= 40; k++) begin
            tick(has(q, k), k == 12);
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL reset_mid edge %0d: got %b want %b", k, dut_vec(), mdl_vec());
            end
            if (k == 12) begin
                n_tests++;
                if (dut_vec() !== 6'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid_clear: got %b want 000000", dut_vec());
                end
            end
            if (k == 28) begin
                n_tests++;
                if (single_click !== 1'b1 || last_evt !== 2'd1) begin
                    n_fail++;
                    $display("FAIL reset_mid_later_single: got s=%b evt=%0d want 1/1",
                             single_click, last_evt);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int q[$] = '{5, 6, 7, 10, 13, 16, 17};
        restart();
        for (int k = 1; k <= 35; k++) begin
            tick(has(q, k), 1'b0);
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL b2b edge %0d: got %b want %b", k, dut_vec(), mdl_vec());
            end
            if (k == 7 || k == 16) begin
                n_tests++;
                if (triple_click !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_triple_at_%0d: got %b want 1", k, triple_click);
                end
            end
            if (k == 25) begin
                n_tests++;
                if (single_click !== 1'b1 || last_evt !== 2'd1) begin
                    n_fail++;
                    $display("FAIL b2b_single_at_25: got s=%b evt=%0d want 1/1",
                             single_click, last_evt);
                end
            end
        end
    endtask

    task automatic test_random();
        int unsigned density = 3;
        restart();
        for (int k = 1; k <= 4000; k++) begin
            if (k % 200 == 0) density = $urandom_range(2, 14);
            tick(logic'($urandom_range(0, density - 1) == 0),
                 logic'($urandom_range(0, 599) == 0));
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL random edge %0d: got %b want %b", k, dut_vec(), mdl_vec());
            end
            n_tests++;
            if ($countones({single_click, double_click, triple_click}) > 1) begin
                n_fail++;
                $display("FAIL random_onehot edge %0d: got %b want at most one set", k,
                         {single_click, double_click, triple_click});
            end
        end
    endtask

    initial begin
        e       = 0;
        burst_n = 0;
        last_t  = 0;
        m_evt   = 2'd0;
        test_reset();
        test_single();
        test_double();
        test_triple();
        test_window_boundary();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
